// File: rtl/a2bus_pkg.sv
// Shared definitions for the Apple II slot-bus arbitration logic.
package a2bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_DRIVE  = 2'd2
    } arb_state_t;

    localparam logic [15:0] CONFLICT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == CONFLICT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bus_slot_arbiter_rr_priority_pick.sv
// Combinational rotating-priority picker: index ptr_i has top priority,
// search proceeds upward with wrap. Pointer 0 gives fixed lowest-index priority.
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] win_o
);

    localparam logic [PTR_W:0] NUM_W = NUM_REQ[PTR_W:0];

    logic             found;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        win_o = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_i} + (PTR_W+1)'(i);
            if (sum >= NUM_W) sum = sum - NUM_W;
            idx = sum[PTR_W-1:0];
            if (!found && req_i[idx]) begin
                win_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_slot_arbiter.sv
// Slot-bus read-drive arbiter: one card per phi0 cycle drives the data bus,
// with conflict accounting and a combined, maskable IRQ output.
module bus_slot_arbiter
    import a2bus_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                 clk_logic,
    input  logic                 system_reset_n,
    input  logic                 cycle_start_i,
    input  logic                 cycle_end_i,
    input  logic [NUM_REQ-1:0]   rd_en_i,
    input  logic [NUM_REQ*8-1:0] data_i,
    input  logic [NUM_REQ-1:0]   irq_n_i,
    input  logic [NUM_REQ-1:0]   irq_mask_i,
    output logic                 data_out_en_o,
    output logic [7:0]           data_out_o,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 irq_n_o,
    output logic                 conflict_o,
    output logic [15:0]          conflict_count_o
);

    localparam int               PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [7:0]         data_q, data_d;
    logic               irq_q, irq_d;
    logic               conflict_q, conflict_d;
    logic [15:0]        count_q, count_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] rd_en_prev_q, rd_en_prev_d;

    logic               decide;
    logic               multi;
    logic [NUM_REQ-1:0] win;
    logic [NUM_REQ-1:0] rise;
    logic [PTR_W-1:0]   pick_ptr;
    logic [PTR_W-1:0]   win_idx;
    logic [7:0]         sel_data;

    assign pick_ptr = (ROUND_ROBIN != 0) ? ptr_q : '0;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_i (rd_en_i),
        .ptr_i (pick_ptr),
        .win_o (win)
    );

    // FSM: state register
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) state_q <= ST_IDLE;
        else                 state_q <= state_d;
    end

    // FSM: next state. A start pulse always wins: it closes the current
    // cycle (implicit end) and opens a fresh SAMPLE window with no grant.
    always_comb begin
        state_d = state_q;
        decide  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cycle_start_i) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (cycle_start_i)    state_d = ST_SAMPLE;
                else if (cycle_end_i) state_d = ST_IDLE;
                else if (|rd_en_i) begin
                    state_d = ST_DRIVE;
                    decide  = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (cycle_start_i)    state_d = ST_SAMPLE;
                else if (cycle_end_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        data_out_en_o = (state_q == ST_DRIVE);
    end

    always_comb begin
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (win[k]) win_idx = PTR_W'(k);
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (grant_q[k]) sel_data = sel_data | data_i[k*8 +: 8];
    end

    assign multi = |(rd_en_i & (rd_en_i - ONE));
    assign rise  = rd_en_i & ~rd_en_prev_q & ~grant_q;

    always_comb begin
        grant_d = grant_q;
        if (decide)                  grant_d = win;
        else if (state_d != ST_DRIVE) grant_d = '0;

        conflict_d = (decide && multi) || ((state_q == ST_DRIVE) && (|rise));
        count_d    = conflict_d ? sat_inc16(count_q) : count_q;

        // Only a contested decision rotates priority.
        ptr_d = ptr_q;
        if ((ROUND_ROBIN != 0) && decide && multi)
            ptr_d = (win_idx == LAST) ? '0 : win_idx + PTR_W'(1);

        data_d       = (state_q == ST_DRIVE) ? sel_data : data_q;
        irq_d        = &(irq_n_i | ~irq_mask_i);
        rd_en_prev_d = rd_en_i;
    end

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            grant_q      <= '0;
            data_q       <= 8'h00;
            irq_q        <= 1'b1;
            conflict_q   <= 1'b0;
            count_q      <= 16'h0000;
            ptr_q        <= '0;
            rd_en_prev_q <= '0;
        end else begin
            grant_q      <= grant_d;
            data_q       <= data_d;
            irq_q        <= irq_d;
            conflict_q   <= conflict_d;
            count_q      <= count_d;
            ptr_q        <= ptr_d;
            rd_en_prev_q <= rd_en_prev_d;
        end
    end

    assign grant_o          = grant_q;
    assign data_out_o       = data_q;
    assign irq_n_o          = irq_q;
    assign conflict_o       = conflict_q;
    assign conflict_count_o = count_q;

endmodule

// File: tb/tb_bus_slot_arbiter.sv
// Directed bench for bus_slot_arbiter (NUM_REQ=4, round-robin).
module tb_bus_slot_arbiter;

    logic        clk_logic = 1'b0;
    logic        system_reset_n;
    logic        cycle_start_i, cycle_end_i;
    logic [3:0]  rd_en_i, irq_n_i, irq_mask_i;
    logic [31:0] data_i;
    logic        data_out_en_o, irq_n_o, conflict_o;
    logic [7:0]  data_out_o;
    logic [3:0]  grant_o;
    logic [15:0] conflict_count_o;

    int n_chk  = 0;
    int n_pass = 0;

    bus_slot_arbiter #(.NUM_REQ(4), .ROUND_ROBIN(1)) dut (
        .clk_logic        (clk_logic),
        .system_reset_n   (system_reset_n),
        .cycle_start_i    (cycle_start_i),
        .cycle_end_i      (cycle_end_i),
        .rd_en_i          (rd_en_i),
        .data_i           (data_i),
        .irq_n_i          (irq_n_i),
        .irq_mask_i       (irq_mask_i),
        .data_out_en_o    (data_out_en_o),
        .data_out_o       (data_out_o),
        .grant_o          (grant_o),
        .irq_n_o          (irq_n_o),
        .conflict_o       (conflict_o),
        .conflict_count_o (conflict_count_o)
    );

    always #5 clk_logic = ~clk_logic;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_logic);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_en"},    {31'd0, data_out_en_o}, 32'd0);
        chk({tag, "_grant"}, {28'd0, grant_o},       32'd0);
        chk({tag, "_data"},  {24'd0, data_out_o},    32'd0);
        chk({tag, "_irq"},   {31'd0, irq_n_o},       32'd1);
        chk({tag, "_cfl"},   {31'd0, conflict_o},    32'd0);
        chk({tag, "_cnt"},   {16'd0, conflict_count_o}, 32'd0);
    endtask

    initial begin
        system_reset_n = 1'b0;
        cycle_start_i  = 1'b0;
        cycle_end_i    = 1'b0;
        rd_en_i        = 4'b0000;
        irq_n_i        = 4'b1111;
        irq_mask_i     = 4'b0000;
        data_i         = {8'h3C, 8'hA5, 8'h22, 8'h11};
        step(); step();
        chk_reset_vals("rst");
        system_reset_n = 1'b1;
        step();

        // single requester card2
        cycle_start_i = 1'b1; step();
        cycle_start_i = 1'b0; rd_en_i = 4'b0100; step();
        chk("s_en",    {31'd0, data_out_en_o}, 32'd1);
        chk("s_grant", {28'd0, grant_o}, 32'h4);
        chk("s_cfl",   {31'd0, conflict_o}, 32'd0);
        rd_en_i = 4'b0000; step();
        chk("s_data",  {24'd0, data_out_o}, 32'hA5);
        chk("s_en_hold", {31'd0, data_out_en_o}, 32'd1);
        cycle_end_i = 1'b1; step();
        cycle_end_i = 1'b0;
        chk("s_en_off",    {31'd0, data_out_en_o}, 32'd0);
        chk("s_grant_off", {28'd0, grant_o}, 32'h0);
        data_i[23:16] = 8'h5A; step();
        chk("s_data_hold", {24'd0, data_out_o}, 32'hA5);

        // two-way conflicts rotate priority: card0 then card1
        cycle_start_i = 1'b1; step();
        cycle_start_i = 1'b0; rd_en_i = 4'b0011; step();
        chk("c1_grant", {28'd0, grant_o}, 32'h1);
        chk("c1_cfl",   {31'd0, conflict_o}, 32'd1);
        chk("c1_cnt",   {16'd0, conflict_count_o}, 32'd1);
        rd_en_i = 4'b0000; step();
        chk("c1_cfl_off", {31'd0, conflict_o}, 32'd0);
        chk("c1_data",  {24'd0, data_out_o}, 32'h11);
        cycle_end_i = 1'b1; step();
        cycle_end_i = 1'b0; cycle_start_i = 1'b1; step();
        cycle_start_i = 1'b0; rd_en_i = 4'b0011; step();
        chk("c2_grant", {28'd0, grant_o}, 32'h2);
        chk("c2_cnt",   {16'd0, conflict_count_o}, 32'd2);
        step();
        chk("c2_data",  {24'd0, data_out_o}, 32'h22);
        rd_en_i = 4'b0000; cycle_end_i = 1'b1; step();
        cycle_end_i = 1'b0;

        // winner drops mid-DRIVE, card3 rises mid-DRIVE
        cycle_start_i = 1'b1; step();
        cycle_start_i = 1'b0; rd_en_i = 4'b0001; step();
        chk("d_grant", {28'd0, grant_o}, 32'h1);
        chk("d_cfl0",  {31'd0, conflict_o}, 32'd0);
        rd_en_i = 4'b0000; step();
        chk("d_en_drop", {31'd0, data_out_en_o}, 32'd1);
        rd_en_i = 4'b1000; step();
        chk("d_cfl_rise", {31'd0, conflict_o}, 32'd1);
        chk("d_grant_keep", {28'd0, grant_o}, 32'h1);
        step();
        chk("d_cfl_once", {31'd0, conflict_o}, 32'd0);
        chk("d_cnt", {16'd0, conflict_count_o}, 32'd3);
        cycle_end_i = 1'b1; step();
        cycle_end_i = 1'b0;
        chk("d_en_off", {31'd0, data_out_en_o}, 32'd0);

        // ptr still 2 after the uncontested grant
        rd_en_i = 4'b0000; cycle_start_i = 1'b1; step();
        cycle_start_i = 1'b0; rd_en_i = 4'b0111; step();
        chk("p_grant", {28'd0, grant_o}, 32'h4);
        chk("p_cnt",   {16'd0, conflict_count_o}, 32'd4);
        // start and end together: back to SAMPLE with no grant
        cycle_start_i = 1'b1; cycle_end_i = 1'b1; step();
        cycle_start_i = 1'b0; cycle_end_i = 1'b0;
        chk("se_en",    {31'd0, data_out_en_o}, 32'd0);
        chk("se_grant", {28'd0, grant_o}, 32'h0);
        chk("se_cfl",   {31'd0, conflict_o}, 32'd0);
        rd_en_i = 4'b1001; step();
        chk("se_grant2", {28'd0, grant_o}, 32'h8);
        chk("se_cnt",    {16'd0, conflict_count_o}, 32'd5);
        rd_en_i = 4'b0000; cycle_end_i = 1'b1; step();
        cycle_end_i = 1'b0;

        // SAMPLE closed with no request: no grant afterwards
        cycle_start_i = 1'b1; step();
        cycle_start_i = 1'b0; cycle_end_i = 1'b1; step();
        cycle_end_i = 1'b0; rd_en_i = 4'b0001; step();
        chk("ne_en",    {31'd0, data_out_en_o}, 32'd0);
        chk("ne_grant", {28'd0, grant_o}, 32'h0);
        rd_en_i = 4'b0000;

        // IRQ combine and mask
        irq_n_i = 4'b1010; irq_mask_i = 4'b1110; step();
        chk("irq_act", {31'd0, irq_n_o}, 32'd0);
        irq_mask_i = 4'b1010;
        #1 chk("irq_lat", {31'd0, irq_n_o}, 32'd0);
        step();
        chk("irq_msk", {31'd0, irq_n_o}, 32'd1);

        // saturation: one conflict per clock
        irq_n_i = 4'b0000; irq_mask_i = 4'b1111;
        cycle_start_i = 1'b1; step();
        for (int i = 0; i < 33000; i++) begin
            rd_en_i = 4'b0011; cycle_start_i = 1'b0; step();
            rd_en_i = 4'b0111; cycle_start_i = 1'b1; step();
        end
        chk("sat_cnt", {16'd0, conflict_count_o}, 32'hFFFF);
        chk("sat_cfl", {31'd0, conflict_o}, 32'd1);
        rd_en_i = 4'b0011; cycle_start_i = 1'b0; step();
        chk("sat_cnt2", {16'd0, conflict_count_o}, 32'hFFFF);
        chk("sat_en",   {31'd0, data_out_en_o}, 32'd1);
        chk("sat_irq",  {31'd0, irq_n_o}, 32'd0);

        // asynchronous reset mid-DRIVE
        #2 system_reset_n = 1'b0;
        #1 chk_reset_vals("arst");
        #10 system_reset_n = 1'b1;
        step();
        chk("post_en", {31'd0, data_out_en_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_slot_arbiter.md
BUS_SLOT_ARBITER -- requirements
Module: bus_slot_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of card requesters (2..8).
REQ-002 SHALL have parameter ROUND_ROBIN, default 1: 1 = rotating priority on conflict; 0 = fixed priority, lowest index wins.
REQ-003 SHALL have clk_logic  in  1  sole clock; all logic on posedge.
REQ-004 SHALL have system_reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have cycle_start_i  in  1  one-clock pulse at phi0 start (phi1 negedge, already in the clk_logic domain).
REQ-006 SHALL have cycle_end_i  in  1  one-clock pulse at phi0 end (phi1 posedge).
REQ-007 SHALL have rd_en_i  in  NUM_REQ  per-card read-drive request.
REQ-008 SHALL have data_i  in  NUM_REQ*8  per-card read data; card k occupies bits [8k+7:8k].
REQ-009 SHALL have irq_n_i  in  NUM_REQ  per-card active-low IRQ.
REQ-010 SHALL have irq_mask_i  in  NUM_REQ  1 = source enabled.
REQ-011 SHALL have data_out_en_o  out  1  drive Apple data bus.
REQ-012 SHALL have data_out_o  out  8  bus data.
REQ-013 SHALL have grant_o  out  NUM_REQ  one-hot current grant.
REQ-014 SHALL have irq_n_o  out  1  combined active-low IRQ.
REQ-015 SHALL have conflict_o  out  1  one-clock pulse per conflict.
REQ-016 SHALL have conflict_count_o  out  16  saturating conflict count.

Function
REQ-017 SHALL implement FSM states IDLE, SAMPLE, DRIVE.
REQ-018 IDLE -> SAMPLE on cycle_start_i.
REQ-019 SAMPLE: on the first clock with any rd_en_i bit set, SHALL select a winner, latch grant_o, and enter DRIVE.
REQ-020 SAMPLE -> IDLE on cycle_end_i with no request; no grant.
REQ-021 DRIVE: grant_o and data_out_en_o SHALL stay asserted until cycle_end_i, even if the winner drops rd_en_i; DRIVE -> IDLE on cycle_end_i.
REQ-022 data_out_o SHALL be registered from the granted card's data_i each clock while in DRIVE (1-clock latency) and hold its last value otherwise.
REQ-023 data_out_en_o and grant_o SHALL assert the clock after the request is first seen in SAMPLE and deassert the clock after cycle_end_i.
REQ-024 Conflict: more than one rd_en_i bit at the decision clock, or any non-granted rd_en_i rising during DRIVE, SHALL pulse conflict_o for one clock and increment conflict_count_o.
REQ-025 conflict_count_o SHALL saturate at 16'hFFFF.
REQ-026 Round-robin: a pointer (reset 0) gives top priority to index ptr, searching upward with wrap; after each granted conflict, ptr SHALL become (winner+1) mod NUM_REQ.
REQ-027 The pointer SHALL be unchanged by non-conflicting grants; with ROUND_ROBIN=0 it is unused.
REQ-028 cycle_start_i and cycle_end_i in the same clock: end is processed, then the new cycle starts; next state SAMPLE, grant cleared.
REQ-029 cycle_start_i while in SAMPLE or DRIVE SHALL be treated as an implicit end plus a new start.
REQ-030 irq_n_o SHALL be registered: AND over k of (irq_n_i[k] | ~irq_mask_i[k]); 1-clock latency, independent of FSM state.

Reset
REQ-031 While system_reset_n is low: state IDLE, grant_o 0, data_out_en_o 0, data_out_o 8'h00, irq_n_o 1, conflict_o 0, conflict_count_o 0, ptr 0.
REQ-032 Reset asserted mid-DRIVE SHALL drop data_out_en_o asynchronously, without waiting for a clock.

Structure
REQ-033 The arb_state_t enum and the CONFLICT_MAX constant SHALL live in the shared a2bus package.
REQ-034 Winner selection SHALL be a combinational sub-module, rr_priority_pick (inputs: request vector, pointer; output: one-hot winner), reused for fixed priority with pointer 0.

Verification
REQ-035 start; rd_en=4'b0100, data card2=8'hA5 -> en=1 and grant=4'b0100 next clock, data_out=8'hA5 one clock later, hold until end +1.
REQ-036 rd_en=4'b0011, RR, ptr=0 -> card0 wins, conflict pulse, count=1, ptr=1; repeat -> card1 wins, count=2.
REQ-037 Winner drops rd_en mid-DRIVE -> en stays 1 until end; card3 rises mid-DRIVE -> conflict pulse, grant unchanged.
REQ-038 irq_n=4'b1010, mask=4'b1110 -> irq_n_o=0; mask=4'b1010 -> irq_n_o=1 after 1 clock.
REQ-039 Count preloaded via 65535 conflicts -> stays 16'hFFFF; reset asserted mid-DRIVE -> en=0 immediately, all outputs at REQ-031 values.
